// File: rtl/frontend_line_adapter_pkg.sv
// Shared command encodings, FSM states and chunk geometry for the frontend line adapter.
// Command values must match the ORAM frontend's decoder.
package frontend_line_adapter_pkg;

    localparam logic [1:0] CmdWrite   = 2'd0;
    localparam logic [1:0] CmdAppend  = 2'd1;
    localparam logic [1:0] CmdRead    = 2'd2;
    localparam logic [1:0] CmdReadRmv = 2'd3;

    localparam int DefORAMB       = 512;
    localparam int DefFEDWidth    = 64;
    localparam int ChunkCount     = DefORAMB / DefFEDWidth;
    localparam int ChunkIdxWidth  = $clog2(ChunkCount);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StIssueCmd   = 3'd1,
        StSendData   = 3'd2,
        StWaitReturn = 3'd3,
        StRespond    = 3'd4
    } state_t;

    function automatic int chunkIdxWidth(input int blockWidth, input int chunkWidth);
        return $clog2(blockWidth / chunkWidth);
    endfunction

endpackage

// File: rtl/line_chunk_serdes.sv
// Block <-> chunk serialiser/deserialiser sharing one chunk index; 1 cycle per chunk.
// No backpressure of its own: the parent only pulses shiftOut/capture on a completed handshake.
module line_chunk_serdes
    import frontend_line_adapter_pkg::*;
#(
    parameter int BlockWidth = 512,
    parameter int ChunkWidth = 64
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  load,
    input  logic [BlockWidth-1:0] loadBlock,
    input  logic                  clearIdx,
    input  logic                  shiftOut,
    input  logic                  capture,
    input  logic [ChunkWidth-1:0] chunkIn,
    output logic [ChunkWidth-1:0] chunkOut,
    output logic [BlockWidth-1:0] block,
    output logic                  isLast
);

    localparam int Chunks   = BlockWidth / ChunkWidth;
    localparam int IdxWidth = chunkIdxWidth(BlockWidth, ChunkWidth);

    logic [BlockWidth-1:0] txBlock;
    logic [BlockWidth-1:0] rxBlock;
    logic [IdxWidth-1:0]   idx;

    // Outgoing chunks come from the bottom of a shift register so FEData is a plain flop.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            txBlock <= '0;
            rxBlock <= '0;
            idx     <= '0;
        end else begin
            if (load)
                txBlock <= loadBlock;
            else if (shiftOut)
                txBlock <= txBlock >> ChunkWidth;

            for (int i = 0; i < Chunks; i++) begin
                if (capture && idx == IdxWidth'(i))
                    rxBlock[i*ChunkWidth +: ChunkWidth] <= chunkIn;
            end

            if (clearIdx)
                idx <= '0;
            else if (shiftOut || capture)
                idx <= idx + 1'b1;
        end
    end

    assign chunkOut = txBlock[ChunkWidth-1:0];
    assign block    = rxBlock;
    assign isLast   = (idx == {IdxWidth{1'b1}});

endmodule

// File: rtl/frontend_line_adapter.sv
// Full-block request adapter in front of the ORAM frontend; request-to-command latency 1 cycle.
// One request in flight; every output except ReqReady is a flop, all interfaces honour valid/ready.
module frontend_line_adapter
    import frontend_line_adapter_pkg::*;
#(
    parameter int ORAMU      = 32,
    parameter int ORAMB      = DefORAMB,
    parameter int FEDWidth   = DefFEDWidth,
    parameter int BECMDWidth = 2,
    parameter int DMWidth    = ORAMB / FEDWidth
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    output logic                  ReqReady,
    input  logic                  ReqValid,
    input  logic [BECMDWidth-1:0] ReqCmd,
    input  logic [ORAMU-1:0]      ReqAddr,
    input  logic [DMWidth-1:0]    ReqMask,
    input  logic [ORAMB-1:0]      ReqData,
    input  logic                  RespReady,
    output logic                  RespValid,
    output logic [ORAMB-1:0]      RespData,
    input  logic                  FECmdReady,
    output logic                  FECmdValid,
    output logic [BECMDWidth-1:0] FECmd,
    output logic [ORAMU-1:0]      FEAddr,
    output logic [DMWidth-1:0]    FEWMask,
    input  logic                  FEDataReady,
    output logic                  FEDataValid,
    output logic [FEDWidth-1:0]   FEData,
    output logic                  FEReturnReady,
    input  logic                  FEReturnValid,
    input  logic [FEDWidth-1:0]   FEReturnData,
    output logic                  Busy
);

    localparam logic [BECMDWidth-1:0] WriteCmd  = BECMDWidth'(CmdWrite);
    localparam logic [BECMDWidth-1:0] AppendCmd = BECMDWidth'(CmdAppend);

    state_t state;
    logic   loadBlock;
    logic   clearIdx;
    logic   sendBeat;
    logic   recvBeat;
    logic   lastChunk;
    logic   isDataCmd;

    assign ReqReady  = (state == StIdle);
    assign loadBlock = ReqReady && ReqValid;
    assign clearIdx  = (state == StIssueCmd) && FECmdReady;
    assign sendBeat  = FEDataValid && FEDataReady;
    assign recvBeat  = FEReturnReady && FEReturnValid;
    assign isDataCmd = (FECmd == WriteCmd) || (FECmd == AppendCmd);

    line_chunk_serdes #(
        .BlockWidth (ORAMB),
        .ChunkWidth (FEDWidth)
    ) serdes (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .load      (loadBlock),
        .loadBlock (ReqData),
        .clearIdx  (clearIdx),
        .shiftOut  (sendBeat),
        .capture   (recvBeat),
        .chunkIn   (FEReturnData),
        .chunkOut  (FEData),
        .block     (RespData),
        .isLast    (lastChunk)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state         <= StIdle;
            FECmdValid    <= 1'b0;
            FEDataValid   <= 1'b0;
            FEReturnReady <= 1'b0;
            RespValid     <= 1'b0;
            Busy          <= 1'b0;
            FECmd         <= '0;
            FEAddr        <= '0;
            FEWMask       <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (ReqValid) begin
                        FECmd      <= ReqCmd;
                        FEAddr     <= ReqAddr;
                        FEWMask    <= ReqMask;
                        FECmdValid <= 1'b1;
                        Busy       <= 1'b1;
                        state      <= StIssueCmd;
                    end
                end
                StIssueCmd: begin
                    if (FECmdReady) begin
                        FECmdValid <= 1'b0;
                        if (isDataCmd) begin
                            FEDataValid <= 1'b1;
                            state       <= StSendData;
                        end else begin
                            FEReturnReady <= 1'b1;
                            state         <= StWaitReturn;
                        end
                    end
                end
                StSendData: begin
                    // Mask is advisory to the frontend; every chunk is still transferred.
                    if (FEDataReady && lastChunk) begin
                        FEDataValid <= 1'b0;
                        Busy        <= 1'b0;
                        state       <= StIdle;
                    end
                end
                StWaitReturn: begin
                    if (FEReturnValid && lastChunk) begin
                        FEReturnReady <= 1'b0;
                        RespValid     <= 1'b1;
                        state         <= StRespond;
                    end
                end
                StRespond: begin
                    if (RespReady) begin
                        RespValid <= 1'b0;
                        Busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    FECmdValid    <= 1'b0;
                    FEDataValid   <= 1'b0;
                    FEReturnReady <= 1'b0;
                    RespValid     <= 1'b0;
                    Busy          <= 1'b0;
                    state         <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frontend_line_adapter.sv
// Randomised bench for frontend_line_adapter with an abstract frontend/requester model.
module tb_frontend_line_adapter;
    import frontend_line_adapter_pkg::*;

    localparam int U = 32;
    localparam int B = 512;
    localparam int W = 64;
    localparam int N = B / W;

    logic          Clock = 1'b0;
    logic          ResetN;
    logic          ReqReady, ReqValid;
    logic [1:0]    ReqCmd;
    logic [U-1:0]  ReqAddr;
    logic [N-1:0]  ReqMask;
    logic [B-1:0]  ReqData;
    logic          RespReady, RespValid;
    logic [B-1:0]  RespData;
    logic          FECmdReady, FECmdValid;
    logic [1:0]    FECmd;
    logic [U-1:0]  FEAddr;
    logic [N-1:0]  FEWMask;
    logic          FEDataReady, FEDataValid;
    logic [W-1:0]  FEData;
    logic          FEReturnReady, FEReturnValid;
    logic [W-1:0]  FEReturnData;
    logic          Busy;

    int checks = 0;
    int passes = 0;
    logic [B-1:0] expResp;

    always #5 Clock = ~Clock;

    frontend_line_adapter dut (
        .Clock(Clock), .ResetN(ResetN),
        .ReqReady(ReqReady), .ReqValid(ReqValid), .ReqCmd(ReqCmd), .ReqAddr(ReqAddr),
        .ReqMask(ReqMask), .ReqData(ReqData),
        .RespReady(RespReady), .RespValid(RespValid), .RespData(RespData),
        .FECmdReady(FECmdReady), .FECmdValid(FECmdValid), .FECmd(FECmd), .FEAddr(FEAddr),
        .FEWMask(FEWMask),
        .FEDataReady(FEDataReady), .FEDataValid(FEDataValid), .FEData(FEData),
        .FEReturnReady(FEReturnReady), .FEReturnValid(FEReturnValid), .FEReturnData(FEReturnData),
        .Busy(Busy)
    );

    task automatic check(input string tag, input logic [B-1:0] obs, input logic [B-1:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [B-1:0] randBlock();
        logic [B-1:0] b;
        for (int i = 0; i < B / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic idleStray(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            FEReturnValid = 1'b1;
            FEReturnData  = {$urandom, $urandom};
            @(negedge Clock);
            check("idle_stray_ret_rdy", FEReturnReady, 0);
            check("idle_resp_stable", RespData, expResp);
        end
        FEReturnValid = 1'b0;
    endtask

    // rdyMode: 0 always ready, 1 alternating 1,0,..., 2 random
    task automatic runTxn(input logic [1:0] cmd, input logic [U-1:0] addr, input logic [N-1:0] mask,
                          input logic [B-1:0] blk, input logic [W-1:0] retBase, input int cmdHold,
                          input int rdyMode, input int respHold, input int abortAt);
        logic [B-1:0] expBlk;
        logic [W-1:0] chunk;
        int beat, cyc;
        bit isWrite, sawResp;
        isWrite = (cmd == CmdWrite) || (cmd == CmdAppend);
        expBlk  = '0;
        check("req_ready_idle", ReqReady, 1);
        ReqValid = 1'b1; ReqCmd = cmd; ReqAddr = addr; ReqMask = mask; ReqData = blk;
        FECmdReady = 1'b0;
        @(negedge Clock);
        ReqValid = 1'b0; ReqData = ~blk; ReqAddr = ~addr; ReqMask = ~mask;
        check("cmd_valid", FECmdValid, 1);
        check("cmd_code", FECmd, cmd);
        check("cmd_addr", FEAddr, addr);
        check("cmd_mask", FEWMask, mask);
        check("busy_set", Busy, 1);
        check("req_ready_busy", ReqReady, 0);
        for (int i = 0; i < cmdHold; i++) begin
            @(negedge Clock);
            check("cmd_hold_valid", FECmdValid, 1);
            check("cmd_hold_fields", {FECmd, FEAddr, FEWMask}, {cmd, addr, mask});
            check("no_early_data", FEDataValid, 0);
        end
        FECmdReady = 1'b1;
        @(negedge Clock);
        FECmdReady = 1'b0;
        check("cmd_dropped", FECmdValid, 0);
        beat = 0; cyc = 0; sawResp = 0;
        if (isWrite) begin
            while (beat < N && cyc < 200) begin
                if (beat == abortAt) begin
                    FEDataReady = 1'b0;
                    FEReturnValid = 1'b0;
                    #2 ResetN = 1'b0;
                    #1;
                    check("abort_valids", {FECmdValid, FEDataValid, FEReturnReady, RespValid, Busy}, 0);
                    check("abort_req_ready", ReqReady, 1);
                    check("abort_fedata", FEData, 0);
                    check("abort_fields", {FECmd, FEAddr, FEWMask}, 0);
                    @(negedge Clock);
                    ResetN  = 1'b1;
                    expResp = '0;
                    return;
                end
                chunk = blk[beat*W +: W];
                check("data_valid", FEDataValid, 1);
                check($sformatf("data_chunk%0d", beat), FEData, chunk);
                check("stray_ret_rdy", FEReturnReady, 0);
                if (RespValid) sawResp = 1;
                FEReturnValid = 1'($urandom_range(0, 1));
                FEReturnData  = {$urandom, $urandom};
                case (rdyMode)
                    0:       FEDataReady = 1'b1;
                    1:       FEDataReady = (cyc % 2 == 0);
                    default: FEDataReady = 1'($urandom_range(0, 1));
                endcase
                if (FEDataReady) beat++;
                cyc++;
                @(negedge Clock);
            end
            FEDataReady = 1'b0;
            FEReturnValid = 1'b0;
            check("write_beats", beat, N);
            check("data_done", FEDataValid, 0);
            check("write_back_idle", {ReqReady, Busy}, 2'b10);
            check("no_write_resp", sawResp || RespValid, 0);
            check("write_resp_untouched", RespData, expResp);
        end else begin
            while (beat < N && cyc < 200) begin
                check("ret_ready", FEReturnReady, 1);
                check("no_early_resp", RespValid, 0);
                FEReturnValid = (rdyMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                FEReturnData  = FEReturnValid ? retBase + W'(beat) : {$urandom, $urandom};
                if (FEReturnValid) begin
                    expBlk[beat*W +: W] = retBase + W'(beat);
                    beat++;
                end
                cyc++;
                @(negedge Clock);
            end
            FEReturnValid = 1'b0;
            check("read_beats", beat, N);
            expResp = expBlk;
            check("resp_valid", RespValid, 1);
            check("resp_data", RespData, expBlk);
            check("ret_ready_off", FEReturnReady, 0);
            RespReady = 1'b0;
            for (int i = 0; i < respHold; i++) begin
                @(negedge Clock);
                check("resp_hold_valid", RespValid, 1);
                check("resp_hold_data", RespData, expBlk);
                check("resp_no_req_ready", ReqReady, 0);
            end
            RespReady = 1'b1;
            @(negedge Clock);
            RespReady = 1'b0;
            check("resp_done", RespValid, 0);
            check("read_back_idle", {ReqReady, Busy}, 2'b10);
        end
    endtask

    initial begin
        logic [B-1:0] blk;
        logic [1:0]   cmd;
        ResetN = 1'b0;
        ReqValid = 1'b0; ReqCmd = '0; ReqAddr = '0; ReqMask = '0; ReqData = '0;
        RespReady = 1'b0; FECmdReady = 1'b0; FEDataReady = 1'b0;
        FEReturnValid = 1'b0; FEReturnData = '0;
        expResp = '0;
        repeat (3) @(negedge Clock);
        check("rst_valids", {FECmdValid, FEDataValid, FEReturnReady, RespValid, Busy}, 0);
        check("rst_req_ready", ReqReady, 1);
        check("rst_fields", {FECmd, FEAddr, FEWMask, FEData}, 0);
        check("rst_resp_data", RespData, 0);
        ResetN = 1'b1;
        @(negedge Clock);

        for (int i = 0; i < N; i++) blk[i*W +: W] = 64'h1111_1111_1111_1111 * 64'(i + 1);
        runTxn(CmdWrite, 32'h100, 8'hFF, blk, '0, 0, 0, 0, -1);
        idleStray(3);
        runTxn(CmdRead, 32'h2A0, 8'h00, '0, 64'hA0, 0, 2, 5, -1);
        runTxn(CmdAppend, 32'h340, 8'h0F, randBlock(), '0, 0, 1, 0, -1);
        runTxn(CmdWrite, 32'h380, 8'h3C, randBlock(), '0, 0, 0, 0, -1);
        runTxn(CmdWrite, 32'h3C0, 8'hFF, randBlock(), '0, 0, 0, 0, 4);
        runTxn(CmdWrite, 32'h400, 8'hA5, randBlock(), '0, 0, 2, 0, -1);
        runTxn(CmdWrite, 32'h440, 8'h5A, randBlock(), '0, 10, 0, 0, -1);
        runTxn(CmdReadRmv, 32'h480, 8'h81, '0, {$urandom, $urandom}, 2, 2, 1, -1);

        for (int t = 0; t < 24; t++) begin
            cmd = 2'($urandom_range(0, 3));
            runTxn(cmd, $urandom, 8'($urandom), randBlock(), {$urandom, $urandom},
                   $urandom_range(0, 3), 2, $urandom_range(0, 3), -1);
            if ($urandom_range(0, 3) == 0) idleStray(2);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/frontend_line_adapter.md
Name: frontend_line_adapter

Overview:
- Block-granularity request adapter sitting directly upstream of the ORAM frontend, between the last-level cache/network side and the frontend's split command/data/return interfaces.
- Accepts one full-block request per handshake. Issues the command to the frontend and serialises write data into FEDWidth chunks.
- Reassembles read-return chunks into a full ORAMB-bit block for the requester.
- One request outstanding at a time.

Parameters:
- ORAMU, 32, program address width.
- ORAMB, 512, block width in bits; must be a power-of-two multiple of FEDWidth, ratio at least 2.
- FEDWidth, 64, frontend data chunk width.
- BECMDWidth, 2, command width; encodings Write, Read, ReadRmv, Append from the shared command constants.
- DMWidth, ORAMB/FEDWidth, write mask width, one bit per chunk.

Ports:
- Clock  in  1  system clock
- ResetN  in  1  asynchronous active-low reset
- ReqReady  out  1  adapter can accept a request
- ReqValid  in  1  request valid
- ReqCmd  in  BECMDWidth  command
- ReqAddr  in  ORAMU  program address
- ReqMask  in  DMWidth  per-chunk write mask
- ReqData  in  ORAMB  write block; chunk 0 = bits [FEDWidth-1:0]
- RespReady  in  1  requester accepts response
- RespValid  out  1  read block valid
- RespData  out  ORAMB  assembled read block
- FECmdReady  in  1  frontend accepts command
- FECmdValid  out  1  command valid
- FECmd  out  BECMDWidth  command to frontend
- FEAddr  out  ORAMU  address to frontend
- FEWMask  out  DMWidth  mask to frontend
- FEDataReady  in  1  frontend accepts data chunk
- FEDataValid  out  1  data chunk valid
- FEData  out  FEDWidth  data chunk
- FEReturnReady  out  1  adapter accepts return chunk
- FEReturnValid  in  1  return chunk valid
- FEReturnData  in  FEDWidth  return chunk
- Busy  out  1  request in flight (state not Idle)

Behaviour:
- Reset: ResetN low asynchronously forces state Idle, chunk counter 0, and all valids, FEReturnReady and Busy to 0. FECmd/FEAddr/FEWMask/FEData/RespData are zeroed. An in-flight request is dropped; the frontend is reset in the same domain.
- States: Idle, IssueCmd, SendData, WaitReturn, Respond.
- Idle:
  - ReqReady=1 only here.
  - On ReqValid&ReqReady, register cmd, addr, mask and data, then go to IssueCmd.
  - FECmdValid rises the cycle after acceptance; request-to-command latency is 1 cycle.
- IssueCmd:
  - FECmdValid held with stable fields until FECmdReady.
  - On the handshake, Write/Append go to SendData and Read/ReadRmv go to WaitReturn.
- SendData:
  - FEDataValid=1 and FEData = registered chunk[counter].
  - The counter advances only on FEDataValid&FEDataReady, so chunks go out in order 0..N-1 with N=ORAMB/FEDWidth.
  - All N chunks are sent regardless of mask.
  - Handshake on chunk N-1 returns to Idle; write/append produce no response.
  - Back-to-back chunks are allowed with no bubble when ready stays high.
- WaitReturn:
  - FEReturnReady=1.
  - Each FEReturnValid&FEReturnReady writes FEReturnData into RespData slice [counter].
  - On chunk N-1, go to Respond with RespValid=1 the next cycle.
- Respond:
  - RespValid and RespData held until RespReady, then go to Idle with counter 0.
  - ReqReady stays 0 here; request acceptance is not overlapped with response.
- Outside WaitReturn, FEReturnReady=0; stray returns are back-pressured, never consumed.
- Counter:
  - log2(N) bits, wraps to 0 after chunk N-1.
  - Cleared on entry to SendData/WaitReturn.
- Write mask:
  - Passed through unchanged with the command.
  - Read/ReadRmv pass the mask through but the frontend ignores it.
- Outputs are driven from registers only, with no combinational ready-to-valid paths. The exception is ReqReady, which is decoded from state.

Decomposition:
- Shared package or include holds:
  - the command encodings, already shared with the frontend;
  - the state encoding localparams;
  - the derived constants ChunkCount=ORAMB/FEDWidth and ChunkIdxWidth=log2(ChunkCount).
- One natural sub-module: line_chunk_serdes. It is a counter plus shift/slice logic that serialises a block to chunks and deserialises chunks to a block, with a shared index. The FSM stays in the top.

Test Plan (ORAMB=512, FEDWidth=64, N=8):
- Write 0x100, ReqData chunk i = 0x1111_1111_1111_1111*(i+1), FECmdReady/FEDataReady always 1:
  - FECmd=Write, FEAddr=0x100 one cycle after acceptance.
  - 8 consecutive data beats with values in order.
  - Back to Idle; RespValid never asserted.
- Read 0x2A0:
  - Frontend returns chunks 0xA0..0xA7 with random valid gaps.
  - RespData slice i = 0xA0+i; RespValid held 5 cycles while RespReady=0; ReqReady stays 0 throughout.
- Append with FEDataReady toggling 1,0,1,0:
  - FEData stable while not ready.
  - Exactly 8 beats accepted; counter wraps to 0.
- Stray FEReturnValid asserted while Idle and during SendData: FEReturnReady stays 0 and no data is captured.
- ResetN pulsed low mid-SendData after chunk 3:
  - All valids 0 immediately (asynchronous).
  - Next Write restarts at chunk 0.
- Write with FECmdReady held 0 for 10 cycles:
  - FECmd/FEAddr/FEWMask stable.
  - No FEDataValid before the command handshake.
